// File: rtl/inter_switch_pkg.sv
// inter_switch route scheduler shared types.
// Field maps for ctrl and descriptors, FSM states.
package inter_switch_pkg;

  localparam int CMD_W  = 36;
  localparam int CTRL_W = 19;

  localparam int C_SRC_LSB = 0;
  localparam int C_SRC_W   = 3;
  localparam int C_DST_LSB = 3;
  localparam int C_DST_W   = 4;
  localparam int C_SHC_LSB = 7;
  localparam int C_SHC_W   = 3;
  localparam int C_SHR_LSB = 10;
  localparam int C_SHR_W   = 9;

  localparam int D_BEATS_LSB = 19;
  localparam int D_BEATS_W   = 16;
  localparam int D_WSW_BIT   = 35;

  localparam logic [2:0] SRC_A = 3'd1;
  localparam logic [2:0] SRC_B = 3'd2;
  localparam logic [2:0] SRC_C = 3'd3;
  localparam logic [2:0] SRC_D = 3'd4;
  localparam logic [2:0] SRC_E = 3'd5;
  localparam logic [2:0] SRC_I = 3'd6;

  localparam logic [3:0] DST_A = 4'd0;
  localparam logic [3:0] DST_B = 4'd1;
  localparam logic [3:0] DST_C = 4'd2;
  localparam logic [3:0] DST_D = 4'd3;
  localparam logic [3:0] DST_E = 4'd4;
  localparam logic [3:0] DST_F = 4'd5;
  localparam logic [3:0] DST_G = 4'd6;
  localparam logic [3:0] DST_H = 4'd7;
  localparam logic [3:0] DST_I = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RUN,
    GAP
  } state_e;

  function automatic logic cmd_legal(
    input logic [CMD_W-1:0] c
  );
    logic [C_SRC_W-1:0]   s;
    logic [C_DST_W-1:0]   d;
    logic [D_BEATS_W-1:0] b;
    s = c[C_SRC_LSB +: C_SRC_W];
    d = c[C_DST_LSB +: C_DST_W];
    b = c[D_BEATS_LSB +: D_BEATS_W];
    return (s >= SRC_A) && (s <= SRC_I)
        && (d <= DST_I) && (b != '0);
  endfunction

endpackage

// File: rtl/inter_switch_sched_fifo.sv
// route_cmd_fifo: plain sync FIFO for descriptors.
// Head is read straight from storage.
module route_cmd_fifo
  import inter_switch_pkg::*;
#(
  parameter int W     = CMD_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  // pointer and occupancy update
  always_comb begin
    do_push = push && (cnt_q != (AW+1)'(DEPTH));
    do_pop  = pop && (cnt_q != '0);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // pointer registers, flushed by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage write, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/inter_switch_sched.sv
// inter_switch_sched: opens one route per descriptor,
// counts beats, closes it and moves to the next.
module inter_switch_sched
  import inter_switch_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter int          BEAT_W     = 16,
  parameter logic [18:0] IDLE_CTRL  = 19'h10080
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CMD_W-1:0]  s_cmd_tdata,
  input  logic              s_cmd_tvalid,
  output logic              s_cmd_tready,
  output logic [CTRL_W-1:0] ctrl,
  output logic              weight_switch,
  input  logic              count_switch_tvalid,
  output logic              busy,
  output logic              route_done,
  output logic              cmd_err,
  output logic [15:0]       route_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e             state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               wsw_q, wsw_d;
  logic [BEAT_W-1:0]  beats_q, beats_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [15:0]        rcnt_q, rcnt_d;
  logic               rdy_q, rdy_d;

  logic               push, pop, empty;
  logic [CMD_W-1:0]   head;
  logic [CW-1:0]      fcnt, fcnt_nx;

  assign push = s_cmd_tvalid && rdy_q;

  route_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (s_cmd_tdata),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .count (fcnt)
  );

  // ready tracks the occupancy after this cycle
  always_comb begin
    fcnt_nx = fcnt + CW'(push) - CW'(pop);
    rdy_d   = (fcnt_nx != CW'(FIFO_DEPTH));
  end

  // route FSM, beat counter and output next-state
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    wsw_d   = wsw_q;
    beats_d = beats_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rcnt_d  = rcnt_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = CHECK;
      end
      CHECK: begin
        pop = 1'b1;
        if (cmd_legal(head)) begin
          ctrl_d  = head[CTRL_W-1:0];
          wsw_d   = head[D_WSW_BIT];
          beats_d = head[D_BEATS_LSB +: BEAT_W];
          state_d = RUN;
        end else begin
          err_d   = 1'b1;
          state_d = ((fcnt > CW'(1)) || push)
                  ? CHECK : IDLE;
        end
      end
      RUN: begin
        if (count_switch_tvalid && beats_q != '0) begin
          beats_d = beats_q - 1'b1;
          if (beats_q == BEAT_W'(1)) begin
            ctrl_d[C_SRC_LSB +: C_SRC_W] = '0;
            done_d  = 1'b1;
            rcnt_d  = rcnt_q + 1'b1;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (!empty) begin
          state_d = CHECK;
        end else begin
          state_d = IDLE;
          ctrl_d  = IDLE_CTRL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctrl_q  <= IDLE_CTRL;
      wsw_q   <= 1'b0;
      beats_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rcnt_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      wsw_q   <= wsw_d;
      beats_q <= beats_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rcnt_q  <= rcnt_d;
      rdy_q   <= rdy_d;
    end
  end

  assign s_cmd_tready  = rdy_q;
  assign ctrl          = ctrl_q;
  assign weight_switch = wsw_q;
  assign route_done    = done_q;
  assign cmd_err       = err_q;
  assign route_cnt     = rcnt_q;
  assign busy          = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_inter_switch_sched.sv
// Directed bench for inter_switch_sched.
// Drives and samples on the falling edge.
module tb_inter_switch_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [35:0] s_cmd_tdata = '0;
  logic        s_cmd_tvalid = 1'b0;
  logic        s_cmd_tready;
  logic [18:0] ctrl;
  logic        weight_switch;
  logic        count_switch_tvalid;
  logic        busy;
  logic        route_done;
  logic        cmd_err;
  logic [15:0] route_cnt;

  logic auto_cnt = 1'b0;
  logic man_cnt  = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int open_cnt = 0;

  always #5 clk = ~clk;

  assign count_switch_tvalid = auto_cnt
    ? (ctrl[2:0] != 3'd0) : man_cnt;

  inter_switch_sched dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .s_cmd_tdata         (s_cmd_tdata),
    .s_cmd_tvalid        (s_cmd_tvalid),
    .s_cmd_tready        (s_cmd_tready),
    .ctrl                (ctrl),
    .weight_switch       (weight_switch),
    .count_switch_tvalid (count_switch_tvalid),
    .busy                (busy),
    .route_done          (route_done),
    .cmd_err             (cmd_err),
    .route_cnt           (route_cnt)
  );

  always @(posedge clk) begin
    #1;
    if (route_done) done_cnt++;
    if (cmd_err) err_cnt++;
    if (ctrl[2:0] != 3'd0) open_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [35:0] got,
                     input logic [35:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [35:0] mk(
    input logic        w,
    input logic [15:0] b,
    input logic [8:0]  shr,
    input logic [2:0]  shc,
    input logic [3:0]  d,
    input logic [2:0]  s
  );
    return {w, b, shr, shc, d, s};
  endfunction

  task automatic push(input logic [35:0] c);
    int n = 0;
    while (!s_cmd_tready && n < 40) begin
      tick();
      n++;
    end
    chk("push_rdy", 36'(s_cmd_tready), 36'd1);
    s_cmd_tdata  = c;
    s_cmd_tvalid = 1'b1;
    tick();
    s_cmd_tvalid = 1'b0;
  endtask

  task automatic wait_open();
    int n = 0;
    while (ctrl[2:0] == 3'd0 && n < 20) begin
      tick();
      n++;
    end
    chk("open_wait", 36'(ctrl[2:0] != 3'd0), 36'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [18:0] cv [40];
  logic        wv [40];
  logic        dv [40];

  initial begin
    int a, n2, n6, d0, e0, o0, n;
    logic ok;

    // 1: reset values
    tick();
    tick();
    chk("rst_ctrl", 36'(ctrl), 36'h10080);
    chk("rst_wsw", 36'(weight_switch), 36'd0);
    chk("rst_busy", 36'(busy), 36'd0);
    chk("rst_rdy_lo", 36'(s_cmd_tready), 36'd0);
    chk("rst_rcnt", 36'(route_cnt), 36'd0);
    chk("rst_done", 36'(route_done), 36'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_rdy_hi", 36'(s_cmd_tready), 36'd1);

    // 2: single route, 3 spaced beats
    d0 = done_cnt;
    push(mk(1'b0, 16'd3, 9'd0, 3'd0, 4'd0, 3'd1));
    wait_open();
    chk("t2_ctrl", 36'(ctrl), 36'h00001);
    chk("t2_busy", 36'(busy), 36'd1);
    for (int i = 0; i < 3; i++) begin
      man_cnt = 1'b1;
      tick();
      man_cnt = 1'b0;
      if (i < 2) begin
        chk("t2_src_open", 36'(ctrl[2:0]), 36'd1);
        tick();
        chk("t2_src_hold", 36'(ctrl[2:0]), 36'd1);
      end else begin
        chk("t2_src_shut", 36'(ctrl[2:0]), 36'd0);
        chk("t2_done", 36'(route_done), 36'd1);
        chk("t2_rcnt", 36'(route_cnt), 36'd1);
      end
    end
    tick();
    chk("t2_idle_ctrl", 36'(ctrl), 36'h10080);
    chk("t2_done_n", 36'(done_cnt - d0), 36'd1);
    chk("t2_busy_lo", 36'(busy), 36'd0);

    // 3: back-to-back routes, auto counting
    d0 = done_cnt;
    auto_cnt = 1'b1;
    push(mk(1'b1, 16'd4, 9'h1A5, 3'd3, 4'd7, 3'd2));
    push(mk(1'b0, 16'd2, 9'h0F0, 3'd5, 4'd8, 3'd6));
    for (int k = 0; k < 40; k++) begin
      tick();
      cv[k] = ctrl;
      wv[k] = weight_switch;
      dv[k] = route_done;
    end
    auto_cnt = 1'b0;
    a = -1;
    n2 = 0;
    n6 = 0;
    for (int k = 0; k < 40; k++) begin
      if (a < 0 && cv[k][2:0] == 3'd2) a = k;
      if (cv[k][2:0] == 3'd2) n2++;
      if (cv[k][2:0] == 3'd6) n6++;
    end
    ok = (a >= 0) && (a <= 30);
    chk("t3_found", 36'(ok), 36'd1);
    if (!ok) a = 0;
    chk("t3_a_ctrl", 36'(cv[a]), 36'h695BA);
    chk("t3_a_wsw", 36'(wv[a]), 36'd1);
    chk("t3_a_beats", 36'(n2), 36'd4);
    chk("t3_gap_ctrl", 36'(cv[a+4]), 36'h695B8);
    chk("t3_gap_done", 36'(dv[a+4]), 36'd1);
    chk("t3_chk_src", 36'(cv[a+5][2:0]), 36'd0);
    chk("t3_chk_wsw", 36'(wv[a+5]), 36'd1);
    chk("t3_b_ctrl", 36'(cv[a+6]), 36'h3C2C6);
    chk("t3_b_wsw", 36'(wv[a+6]), 36'd0);
    chk("t3_b_beats", 36'(n6), 36'd2);
    chk("t3_b_close", 36'(cv[a+8]), 36'h3C2C0);
    chk("t3_b_done", 36'(dv[a+8]), 36'd1);
    chk("t3_idle", 36'(cv[a+9]), 36'h10080);
    chk("t3_done_n", 36'(done_cnt - d0), 36'd2);
    chk("t3_rcnt", 36'(route_cnt), 36'd3);

    // 4: illegal descriptors
    do_reset();
    e0 = err_cnt;
    o0 = open_cnt;
    push(mk(1'b0, 16'd1, 9'd0, 3'd0, 4'd0, 3'd0));
    push(mk(1'b0, 16'd1, 9'd0, 3'd0, 4'd0, 3'd7));
    push(mk(1'b0, 16'd1, 9'd0, 3'd0, 4'd9, 3'd1));
    push(mk(1'b1, 16'd0, 9'd0, 3'd0, 4'd0, 3'd1));
    for (int k = 0; k < 10; k++) tick();
    chk("t4_errs", 36'(err_cnt - e0), 36'd4);
    chk("t4_open", 36'(open_cnt - o0), 36'd0);
    chk("t4_ctrl", 36'(ctrl), 36'h10080);
    chk("t4_wsw", 36'(weight_switch), 36'd0);
    chk("t4_rcnt", 36'(route_cnt), 36'd0);
    chk("t4_busy", 36'(busy), 36'd0);

    // 5: fill queue behind a stalled route
    e0 = err_cnt;
    push(mk(1'b0, 16'd2, 9'd0, 3'd0, 4'd1, 3'd1));
    wait_open();
    for (int k = 0; k < 4; k++)
      push(mk(1'b0, 16'd1, 9'd0, 3'd0, 4'd2, 3'd3));
    chk("t5_full_rdy", 36'(s_cmd_tready), 36'd0);
    chk("t5_full_busy", 36'(busy), 36'd1);
    s_cmd_tdata  = mk(1'b1, 16'd1, 9'd0, 3'd0, 4'd4, 3'd5);
    s_cmd_tvalid = 1'b1;
    tick();
    chk("t5_still_full", 36'(s_cmd_tready), 36'd0);
    auto_cnt = 1'b1;
    n = 0;
    while (!s_cmd_tready && n < 30) begin
      tick();
      n++;
    end
    chk("t5_accept", 36'(s_cmd_tready), 36'd1);
    tick();
    s_cmd_tvalid = 1'b0;
    n = 0;
    while (busy && n < 80) begin
      tick();
      n++;
    end
    chk("t5_drain", 36'(busy), 36'd0);
    chk("t5_rcnt", 36'(route_cnt), 36'd6);
    chk("t5_wsw_held", 36'(weight_switch), 36'd1);
    chk("t5_ctrl", 36'(ctrl), 36'h10080);
    chk("t5_errs", 36'(err_cnt - e0), 36'd0);
    auto_cnt = 1'b0;

    // 6: reset in the middle of a route
    push(mk(1'b1, 16'd5, 9'd0, 3'd0, 4'd2, 3'd4));
    wait_open();
    push(mk(1'b0, 16'd1, 9'd0, 3'd0, 4'd0, 3'd1));
    d0 = done_cnt;
    rst_n = 1'b0;
    tick();
    chk("t6_ctrl", 36'(ctrl), 36'h10080);
    chk("t6_wsw", 36'(weight_switch), 36'd0);
    chk("t6_busy", 36'(busy), 36'd0);
    chk("t6_rdy", 36'(s_cmd_tready), 36'd0);
    chk("t6_done", 36'(route_done), 36'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("t6_busy_post", 36'(busy), 36'd0);
    chk("t6_done_n", 36'(done_cnt - d0), 36'd0);
    chk("t6_rcnt", 36'(route_cnt), 36'd0);
    chk("t6_ctrl_post", 36'(ctrl), 36'h10080);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0t exp=done", $time);
    $fatal(1, "timeout");
  end

endmodule
